// File: rtl/ar_m.sv
// ar_m: registered 8-entry table multiplexer.
// A 3-bit select {a,b,c} (a is the MSB) picks one WIDTH-bit entry of an
// internal table, and the entry is registered into q every rising clk.
// The table resets to one-hot defaults (entry i = 1 << i). The write port
// can overwrite entries. A read and a write to the same index in one cycle
// return the old entry.
//
// Ports:
//   clk      in   1      rising-edge clock
//   rst_n    in   1      asynchronous active-low reset
//   a,b,c    in   1      select bits 2,1,0
//   wr_en    in   1      table write enable
//   wr_addr  in   3      table write index
//   wr_data  in   WIDTH  table write data
//   q        out  WIDTH  registered selected entry (0 in reset)
//   q_par    out  1      even parity of q, only when AR_M_PARITY_EN is defined
//
// Build option: define AR_M_PARITY_EN to add the q_par output.
module ar_m #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             a,
   input  logic             b,
   input  logic             c,
   input  logic             wr_en,
   input  logic [2:0]       wr_addr,
   input  logic [WIDTH-1:0] wr_data,
`ifdef AR_M_PARITY_EN
   output logic             q_par,
`endif
   output logic [WIDTH-1:0] q
);

   localparam int unsigned DEPTH = 8;

   logic [2:0]       sel;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] q_d;

   // Next-state: read uses the current table contents, which gives read-before-write.
   always_comb begin
      sel   = {a, b, c};
      mem_d = mem_q;
      q_d   = mem_q[sel];
      if (wr_en) begin
         mem_d[wr_addr] = wr_data;
      end
   end

   // Table and output registers; reset restores the one-hot defaults.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= WIDTH'(1) << i;
         end
         q_q <= '0;
      end else begin
         mem_q <= mem_d;
         q_q   <= q_d;
      end
   end

   assign q = q_q;

`ifdef AR_M_PARITY_EN
   logic par_q;
   logic par_d;

   // Parity of the same entry that is registered into q.
   always_comb begin
      par_d = ^q_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         par_q <= 1'b0;
      end else begin
         par_q <= par_d;
      end
   end

   assign q_par = par_q;
`endif

endmodule

// File: tb/tb_ar_m.sv
// Testbench for ar_m: directed spec scenarios with literal expectations,
// followed by randomized traffic. A table model checks q every cycle.
module tb_ar_m;

   localparam int unsigned W = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         a, b, c;
   logic         wr_en;
   logic [2:0]   wr_addr;
   logic [W-1:0] wr_data;
   logic [W-1:0] q;
`ifdef AR_M_PARITY_EN
   logic         q_par;
`endif

   ar_m #(.WIDTH(W)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .a       (a),
      .b       (b),
      .c       (c),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
`ifdef AR_M_PARITY_EN
      .q_par   (q_par),
`endif
      .q       (q)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   bit cmp_en   = 1'b0;

   // Reference model: the table is a plain array, and q is the entry selected before any write.
   logic [W-1:0] m_mem [8];
   logic [W-1:0] exp_q;
   logic         exp_par;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 8; i++) m_mem[i] = 8'h01 << i;
         exp_q   = '0;
         exp_par = 1'b0;
      end else begin
         exp_q   = m_mem[{a, b, c}];
         exp_par = ^exp_q;
         if (wr_en) m_mem[wr_addr] = wr_data;
      end
   end

   // Compare process: check the DUT against the model on every falling edge.
   always @(negedge clk) begin
      if (cmp_en) begin
         n_checks++;
         if (q === exp_q) n_pass++;
         else $display("FAIL model_q t=%0t got=%h exp=%h", $time, q, exp_q);
`ifdef AR_M_PARITY_EN
         n_checks++;
         if (q_par === exp_par) n_pass++;
         else $display("FAIL model_par t=%0t got=%b exp=%b", $time, q_par, exp_par);
`endif
      end
   end

   task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%h exp=%h", name, got, exp);
   endtask

   task automatic set_sel(input logic [2:0] s);
      {a, b, c} = s;
   endtask

   task automatic tick_check(input string name, input logic [W-1:0] exp);
      @(posedge clk);
      #1;
      chk(name, q, exp);
   endtask

   logic [W-1:0] sweep_exp [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

   initial begin
      rst_n   = 1'b0;
      set_sel(3'd5);
      wr_en   = 1'b0;
      wr_addr = '0;
      wr_data = '0;
      #1;
      chk("reset_q_immediate", q, 8'h00);
      repeat (2) @(posedge clk);
      #1;
      chk("reset_q_held", q, 8'h00);

      // Release reset on a falling edge, then expect entry 5 after one clk.
      @(negedge clk);
      rst_n  = 1'b1;
      cmp_en = 1'b1;
      tick_check("first_after_reset", 8'h20);

      // Select sweep with no writes.
      for (int s = 0; s < 8; s++) begin
         @(negedge clk);
         set_sel(3'(s));
         tick_check($sformatf("sweep_%0d", s), sweep_exp[s]);
      end

      // Write A5 to entry 3, then read entries 3 and 2.
      @(negedge clk);
      set_sel(3'd0);
      wr_en = 1'b1; wr_addr = 3'd3; wr_data = 8'hA5;
      @(negedge clk);
      wr_en = 1'b0;
      set_sel(3'd3);
      tick_check("read_written_3", 8'hA5);
`ifdef AR_M_PARITY_EN
      chk("par_a5", {7'd0, q_par}, 8'h00);
`endif
      @(negedge clk);
      set_sel(3'd2);
      tick_check("read_default_2", 8'h04);

`ifdef AR_M_PARITY_EN
      // Write 07 to entry 3 while selecting it: old value first, then the new one.
      @(negedge clk);
      set_sel(3'd3);
      wr_en = 1'b1; wr_addr = 3'd3; wr_data = 8'h07;
      tick_check("par_collide_old", 8'hA5);
      @(negedge clk);
      wr_en = 1'b0;
      tick_check("par_new_07", 8'h07);
      chk("par_07", {7'd0, q_par}, 8'h01);
`endif

      // Same-cycle read and write of entry 6.
      @(negedge clk);
      set_sel(3'd6);
      wr_en = 1'b1; wr_addr = 3'd6; wr_data = 8'h3C;
      tick_check("collide_old", 8'h40);
      @(negedge clk);
      wr_en = 1'b0;
      tick_check("collide_new", 8'h3C);

      // Asynchronous reset between clock edges: writes are discarded.
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("async_reset_q", q, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
      set_sel(3'd3);
      tick_check("after_reset_default_3", 8'h08);
      @(negedge clk);
      set_sel(3'd6);
      tick_check("after_reset_default_6", 8'h40);

      // Randomized traffic with occasional mid-cycle reset pulses; the compare process checks each cycle.
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         set_sel(3'($urandom_range(0, 7)));
         wr_en   = 1'($urandom_range(0, 1));
         wr_addr = 3'($urandom_range(0, 7));
         wr_data = W'($urandom);
         if ($urandom_range(0, 63) == 0) begin
            #2 rst_n = 1'b0;
            #1;
            chk("random_async_reset", q, 8'h00);
            #1 rst_n = 1'b1;
         end
      end

      @(negedge clk);
      cmp_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
